// File: rtl/bus_ack_gen_pkg.sv
// Shared types and limits for the bus_ack_gen responder.
package bus_ack_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 255;
    localparam int unsigned DEPTH_MIN   = 2;
    localparam int unsigned DEPTH_MAX   = 16;
    localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/bus_ack_gen_if.sv
// Request/acknowledge bus between the requester stage and bus_ack_gen.
interface bus_ack_gen_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) ();

    logic                         bus_req;
    logic [DW-1:0]                bus_data;
    logic                         bus_ack;
    logic [DW-1:0]                ack_data;
    logic [$clog2(DEPTH+1)-1:0]   pending;
    logic                         overflow;

    modport master (
        output bus_req, bus_data,
        input  bus_ack, ack_data, pending, overflow
    );

    modport slave (
        input  bus_req, bus_data,
        output bus_ack, ack_data, pending, overflow
    );

endinterface

// File: rtl/bus_ack_fifo.sv
// DEPTH x DW register FIFO; modulo-DEPTH pointers plus occupancy counter.
module bus_ack_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_ack_gen.sv
// Request responder: FIFO-buffered requests, one single-cycle ack each after LATENCY cycles.
// Optional simulation checks enabled by defining BUS_ACK_GEN_ASSERT_EN.
module bus_ack_gen
    import bus_ack_gen_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DW      = 32
) (
    input  logic         clk,
    input  logic         reset_l,
    bus_ack_gen_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DW-1:0]     head;
    logic [DW-1:0]     ack_q;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              overflow_q;

    assign pop  = (state == ACK) && !empty;
    assign push = bus.bus_req && (!full || pop);

    bus_ack_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (push),
        .pop     (pop),
        .din     (bus.bus_data),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Every new head passes through WAIT loaded with LATENCY-1 (even for
    // LATENCY=1), so its ack lands exactly LATENCY edges after it became head
    // and back-to-back acks are always separated by at least one idle cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (push) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = ACK;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ACK: begin
                if (count > CW'(1) || push) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_M1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ack_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (state == ACK)             ack_q      <= head;
            if (bus.bus_req && !push)     overflow_q <= 1'b1;
        end
    end

    // Outputs come only from registers (state, FIFO storage, held ack data).
    assign bus.bus_ack  = (state == ACK);
    assign bus.ack_data = (state == ACK) ? head : ack_q;
    assign bus.pending  = count;
    assign bus.overflow = overflow_q;

`ifdef BUS_ACK_GEN_ASSERT_EN
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_lat_chk
        $error("bus_ack_gen: LATENCY %0d out of range", LATENCY);
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
        $error("bus_ack_gen: DEPTH %0d out of range", DEPTH);
    end

    logic req_prev;
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            req_prev <= 1'b0;
        end else begin
            req_prev <= bus.bus_req;
            if (bus.bus_req && !push)
                $error("bus_ack_gen: request dropped, FIFO full");
            if (bus.bus_req && req_prev)
                $error("bus_ack_gen: bus_req high on consecutive cycles");
        end
    end
`endif

endmodule

// File: tb/tb_bus_ack_gen.sv
// Directed bench for bus_ack_gen: three instances at LATENCY 2, 1 and 10.
module tb_bus_ack_gen;

    logic clk;
    logic reset_l;

    int unsigned n_checks;
    int unsigned n_pass;

    bus_ack_gen_if #(.DW(32), .DEPTH(4)) if_a ();
    bus_ack_gen_if #(.DW(32), .DEPTH(4)) if_b ();
    bus_ack_gen_if #(.DW(32), .DEPTH(4)) if_c ();

    bus_ack_gen #(.DEPTH(4), .LATENCY(2),  .DW(32)) dut_a (.clk(clk), .reset_l(reset_l), .bus(if_a));
    bus_ack_gen #(.DEPTH(4), .LATENCY(1),  .DW(32)) dut_b (.clk(clk), .reset_l(reset_l), .bus(if_b));
    bus_ack_gen #(.DEPTH(4), .LATENCY(10), .DW(32)) dut_c (.clk(clk), .reset_l(reset_l), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned acks;
        int unsigned consec;
        logic        prev_ack;
        logic [31:0] last_data;
        int unsigned exp_pend [10] = '{1, 2, 2, 2, 1, 1, 0, 0, 0, 0};

        n_checks = 0;
        n_pass   = 0;
        reset_l  = 1'b0;
        if_a.bus_req = 1'b0; if_a.bus_data = '0;
        if_b.bus_req = 1'b0; if_b.bus_data = '0;
        if_c.bus_req = 1'b0; if_c.bus_data = '0;

        #12;
        check("rst_ack",      if_a.bus_ack,  0);
        check("rst_data",     if_a.ack_data, 0);
        check("rst_pending",  if_a.pending,  0);
        check("rst_overflow", if_a.overflow, 0);
        tick();
        reset_l = 1'b1;
        tick();

        // LATENCY=2, single request
        if_a.bus_req = 1'b1; if_a.bus_data = 32'hfeed;
        tick();
        if_a.bus_req = 1'b0;
        check("t1_pend_T", if_a.pending, 1);
        check("t1_ack_T",  if_a.bus_ack, 0);
        tick();
        check("t1_ack_T1", if_a.bus_ack, 0);
        tick();
        check("t1_ack_T2",  if_a.bus_ack,  1);
        check("t1_data_T2", if_a.ack_data, 32'hfeed);
        check("t1_pend_T2", if_a.pending,  1);
        tick();
        check("t1_ack_T3",  if_a.bus_ack,  0);
        check("t1_pend_T3", if_a.pending,  0);
        check("t1_hold_T3", if_a.ack_data, 32'hfeed);
        check("t1_ovf",     if_a.overflow, 0);

        // LATENCY=1, three back-to-back requests
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                if_b.bus_req  = 1'b1;
                if_b.bus_data = 32'(i + 1);
            end else begin
                if_b.bus_req = 1'b0;
            end
            tick();
            check($sformatf("t2_ack_%0d", i), if_b.bus_ack, (i == 1 || i == 3 || i == 5) ? 1 : 0);
            if (i == 1 || i == 3 || i == 5)
                check($sformatf("t2_data_%0d", i), if_b.ack_data, 64'((i + 1) / 2));
            check($sformatf("t2_pend_%0d", i), if_b.pending, 64'(exp_pend[i]));
        end
        check("t2_ovf", if_b.overflow, 0);

        // LATENCY=10: full FIFO, new request on the head's pop edge
        for (int i = 0; i < 4; i++) begin
            if_c.bus_req = 1'b1; if_c.bus_data = 32'h100 + 32'(i);
            tick();
        end
        if_c.bus_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t4_ack_pre", if_c.bus_ack, 0);
        check("t4_pend_full", if_c.pending, 4);
        tick();
        check("t4_ack_head",  if_c.bus_ack,  1);
        check("t4_data_head", if_c.ack_data, 32'h100);
        if_c.bus_req = 1'b1; if_c.bus_data = 32'h104;
        tick();
        if_c.bus_req = 1'b0;
        check("t4_pend_pp", if_c.pending,  4);
        check("t4_ovf_pp",  if_c.overflow, 0);
        check("t4_ack_pp",  if_c.bus_ack,  0);
        acks = 0; last_data = '0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if_c.bus_ack) begin
                acks++;
                last_data = if_c.ack_data;
            end
        end
        check("t4_acks",  acks,          4);
        check("t4_last",  last_data,     32'h104);
        check("t4_pend0", if_c.pending,  0);
        check("t4_ovf",   if_c.overflow, 0);

        // Reset during WAIT with three queued
        for (int i = 0; i < 3; i++) begin
            if_c.bus_req = 1'b1; if_c.bus_data = 32'h7 + 32'(i);
            tick();
        end
        if_c.bus_req = 1'b0;
        tick(); tick();
        check("t5_pend3", if_c.pending, 3);
        #2;
        reset_l = 1'b0;
        #1;
        check("t5_rst_pend", if_c.pending,  0);
        check("t5_rst_ack",  if_c.bus_ack,  0);
        check("t5_rst_data", if_c.ack_data, 0);
        tick();
        reset_l = 1'b1;
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if_c.bus_ack) acks++;
        end
        check("t5_no_ack", acks, 0);
        if_c.bus_req = 1'b1; if_c.bus_data = 32'habc;
        tick();
        if_c.bus_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("t5_ack_%0d", i), if_c.bus_ack, (i == 10) ? 1 : 0);
        end
        check("t5_data", if_c.ack_data, 32'habc);
        tick();
        check("t5_pend0", if_c.pending, 0);

        // LATENCY=10: six requests, two dropped
        check("t3_ovf_init", if_c.overflow, 0);
        for (int i = 0; i < 6; i++) begin
            if_c.bus_req = 1'b1; if_c.bus_data = 32'h200 + 32'(i);
            tick();
        end
        if_c.bus_req = 1'b0;
        check("t3_pend", if_c.pending,  4);
        check("t3_ovf",  if_c.overflow, 1);
        acks = 0; consec = 0; prev_ack = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (if_c.bus_ack) acks++;
            if (if_c.bus_ack && prev_ack) consec++;
            prev_ack = if_c.bus_ack;
        end
        check("t3_acks",     acks,          4);
        check("t3_consec",   consec,        0);
        check("t3_ovf_held", if_c.overflow, 1);
        check("t3_pend0",    if_c.pending,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
